// File: rtl/minutes_hours_counter_pkg.sv
// Shared constants, mode encoding and 12-hour display helper for the minutes/hours stage.
// The helper is only used when TWELVE_HOUR_EN is defined.
package minutes_hours_counter_pkg;

    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } mode_e;

    // Hour 0 reads as 12; afternoon hours fold back onto 1-11.
    function automatic logic [HOUR_W-1:0] to12Hour(input logic [HOUR_W-1:0] hour24);
        if (hour24 == HOUR_W'(0)) begin
            return HOUR_W'(12);
        end else if (hour24 > HOUR_W'(12)) begin
            return hour24 - HOUR_W'(12);
        end else begin
            return hour24;
        end
    endfunction

endpackage

// File: rtl/minutes_hours_counter_if.sv
// Bundle of the minutes/hours stage pulses and time outputs.
// master drives the buttons and carry, slave is the counter side.
interface minutes_hours_counter_if;

    logic       sec_carry;
    logic       mode_btn;
    logic       inc_btn;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       pm;
    logic [1:0] mode;
    logic       sec_hold;
    logic       sec_clr;
    logic       day_carry;

    modport master (
        output sec_carry, mode_btn, inc_btn,
        input  minutes, hours, pm, mode, sec_hold, sec_clr, day_carry
    );

    modport slave (
        input  sec_carry, mode_btn, inc_btn,
        output minutes, hours, pm, mode, sec_hold, sec_clr, day_carry
    );

endinterface

// File: rtl/minutes_hours_counter_mod_n_counter.sv
// Modulo-(MAX+1) counter with synchronous clear to INIT; wrap flags the MAX->0 step.
// Used once for minutes and once for hours.
module mod_n_counter
    import minutes_hours_counter_pkg::*;
#(
    parameter int WIDTH = MIN_W,
    parameter int MAX   = MIN_MAX,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Terminal value is tested before incrementing, so out-of-range codes never appear.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = INIT_V;
        end else if (inc) begin
            value_d = (value_q == MAX_V) ? '0 : value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= INIT_V;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign wrap  = inc && !clr && (value_q == MAX_V);

endmodule

// File: rtl/minutes_hours_counter.sv
// Minutes/hours stage of a clock with RUN / SET_H / SET_M modes.
// Define TWELVE_HOUR_EN for a 1-12 hour display with PM flag; default shows 0-23.
module minutes_hours_counter
    import minutes_hours_counter_pkg::*;
#(
    parameter int RESET_HOUR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reset,
    input  logic       sec_carry,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       pm,
    output logic [1:0] mode,
    output logic       sec_hold,
    output logic       sec_clr,
    output logic       day_carry
);

    mode_e              mode_q;
    logic               secClr_q;
    logic               runTick;
    logic               setHInc;
    logic               setMInc;
    logic               minInc;
    logic               hourInc;
    logic               minWrap;
    logic               hourWrap;
    logic [MIN_W-1:0]   minVal;
    logic [HOUR_W-1:0]  hourVal;

    // mode_btn takes priority, so a simultaneous inc_btn is dropped.
    assign runTick = (mode_q == RUN) && sec_carry && !reset;
    assign setHInc = (mode_q == SET_H) && inc_btn && !mode_btn;
    assign setMInc = (mode_q == SET_M) && inc_btn && !mode_btn;
    assign minInc  = runTick || setMInc;
    assign hourInc = (runTick && minWrap) || setHInc;

    mod_n_counter #(
        .WIDTH (MIN_W),
        .MAX   (MIN_MAX),
        .INIT  (0)
    ) u_minutes (
        .clk   (clk),
        .rst   (rst),
        .inc   (minInc),
        .clr   (reset),
        .value (minVal),
        .wrap  (minWrap)
    );

    mod_n_counter #(
        .WIDTH (HOUR_W),
        .MAX   (HOUR_MAX),
        .INIT  (RESET_HOUR)
    ) u_hours (
        .clk   (clk),
        .rst   (rst),
        .inc   (hourInc),
        .clr   (reset),
        .value (hourVal),
        .wrap  (hourWrap)
    );

    // sec_clr restarts the seconds stage on the first cycle back in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= RUN;
            secClr_q <= 1'b0;
        end else if (reset) begin
            mode_q   <= RUN;
            secClr_q <= 1'b0;
        end else begin
            secClr_q <= 1'b0;
            if (mode_btn) begin
                case (mode_q)
                    RUN:   mode_q <= SET_H;
                    SET_H: mode_q <= SET_M;
                    SET_M: begin
                        mode_q   <= RUN;
                        secClr_q <= 1'b1;
                    end
                    default: mode_q <= RUN;
                endcase
            end
        end
    end

    assign day_carry = runTick && hourWrap && rst;
    assign sec_hold  = (mode_q != RUN) && rst && !reset;
    assign sec_clr   = secClr_q;
    assign mode      = mode_q;
    assign minutes   = minVal;

`ifdef TWELVE_HOUR_EN
    assign hours = to12Hour(hourVal);
    assign pm    = (hourVal >= HOUR_W'(12));
`else
    assign hours = hourVal;
    assign pm    = 1'b0;
`endif

endmodule

// File: tb/tb_minutes_hours_counter.sv
// Directed vector table plus hand sequences for rollover, frozen time and mid-set resets.
// Expected hours/pm follow TWELVE_HOUR_EN when it is defined.
module tb_minutes_hours_counter;
    import minutes_hours_counter_pkg::*;

    typedef struct {
        logic       sc;
        logic       mb;
        logic       ib;
        logic       rs;
        logic       expDc;
        int         expMin;
        int         expHour;
        logic [1:0] expMode;
        logic       expHold;
        logic       expClr;
        string      name;
    } vec_t;

    logic clk;
    logic rst;
    logic reset;
    int   compared;
    int   mismatched;

    minutes_hours_counter_if hmIf ();

    minutes_hours_counter #(.RESET_HOUR(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .reset     (reset),
        .sec_carry (hmIf.sec_carry),
        .mode_btn  (hmIf.mode_btn),
        .inc_btn   (hmIf.inc_btn),
        .minutes   (hmIf.minutes),
        .hours     (hmIf.hours),
        .pm        (hmIf.pm),
        .mode      (hmIf.mode),
        .sec_hold  (hmIf.sec_hold),
        .sec_clr   (hmIf.sec_clr),
        .day_carry (hmIf.day_carry)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int dispHour(input int h);
`ifdef TWELVE_HOUR_EN
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
`else
        return h;
`endif
    endfunction

    function automatic int dispPm(input int h);
`ifdef TWELVE_HOUR_EN
        return (h >= 12) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    function automatic vec_t mkVec(input logic sc, input logic mb, input logic ib, input logic rs,
                                   input logic dc, input int m, input int h, input logic [1:0] md,
                                   input logic hold, input logic clr, input string name);
        vec_t v;
        v.sc = sc; v.mb = mb; v.ib = ib; v.rs = rs; v.expDc = dc;
        v.expMin = m; v.expHour = h; v.expMode = md;
        v.expHold = hold; v.expClr = clr; v.name = name;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, checking the combinational outputs before the edge.
    task automatic applyStimulus(input logic sc, input logic mb, input logic ib, input logic rs,
                                 input logic expDc, input logic expHoldNow, input string name);
        @(negedge clk);
        hmIf.sec_carry = sc;
        hmIf.mode_btn  = mb;
        hmIf.inc_btn   = ib;
        reset          = rs;
        #1;
        cmp({name, ".day_carry"}, 32'(hmIf.day_carry), 32'(expDc));
        cmp({name, ".sec_hold_now"}, 32'(hmIf.sec_hold), 32'(expHoldNow));
        @(posedge clk);
        #1;
        hmIf.sec_carry = 1'b0;
        hmIf.mode_btn  = 1'b0;
        hmIf.inc_btn   = 1'b0;
        reset          = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int expMin, input int expHour,
                               input logic [1:0] expMode, input logic expHold, input logic expClr);
        cmp({name, ".minutes"}, 32'(hmIf.minutes), 32'(expMin));
        cmp({name, ".hours"}, 32'(hmIf.hours), 32'(dispHour(expHour)));
        cmp({name, ".pm"}, 32'(hmIf.pm), 32'(dispPm(expHour)));
        cmp({name, ".mode"}, 32'(hmIf.mode), 32'(expMode));
        cmp({name, ".sec_hold"}, 32'(hmIf.sec_hold), 32'(expHold));
        cmp({name, ".sec_clr"}, 32'(hmIf.sec_clr), 32'(expClr));
    endtask

    initial begin
        vec_t       vecs[$];
        logic [1:0] prevMode;
        logic       holdNow;

        compared       = 0;
        mismatched     = 0;
        rst            = 1'b0;
        reset          = 1'b0;
        hmIf.sec_carry = 1'b0;
        hmIf.mode_btn  = 1'b0;
        hmIf.inc_btn   = 1'b0;

        //                   sc    mb    ib    rs    dc    min hr  mode   hold  clr
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, RUN,   1'b0, 1'b0, "run_tick"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, RUN,   1'b0, 1'b0, "inc_in_run"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, SET_H, 1'b1, 1'b0, "to_set_h"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1, SET_H, 1'b1, 1'b0, "set_h_inc1"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 2, SET_H, 1'b1, 1'b0, "set_h_inc2"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 3, SET_H, 1'b1, 1'b0, "set_h_inc3"));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 3, SET_H, 1'b1, 1'b0, "set_h_frozen"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 3, SET_M, 1'b1, 1'b0, "collision"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 3, SET_M, 1'b1, 1'b0, "set_m_inc1"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 3, SET_M, 1'b1, 1'b0, "set_m_inc2"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4, 3, SET_M, 1'b1, 1'b0, "set_m_inc3"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5, 3, SET_M, 1'b1, 1'b0, "set_m_inc4"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6, 3, SET_M, 1'b1, 1'b0, "set_m_inc5"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6, 3, RUN,   1'b0, 1'b1, "to_run"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6, 3, RUN,   1'b0, 1'b0, "clr_drops"));
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7, 3, RUN,   1'b0, 1'b0, "run_tick2"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7, 3, SET_H, 1'b1, 1'b0, "to_set_h2"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, RUN,   1'b0, 1'b0, "sync_reset"));

        repeat (2) @(negedge clk);
        checkOutput("async_reset", 0, 0, RUN, 1'b0, 1'b0);
        rst = 1'b1;

        prevMode = RUN;
        for (int i = 0; i < vecs.size(); i++) begin
            holdNow = (prevMode != RUN) && !vecs[i].rs;
            applyStimulus(vecs[i].sc, vecs[i].mb, vecs[i].ib, vecs[i].rs, vecs[i].expDc, holdNow, vecs[i].name);
            checkOutput(vecs[i].name, vecs[i].expMin, vecs[i].expHour, vecs[i].expMode, vecs[i].expHold, vecs[i].expClr);
            prevMode = vecs[i].expMode;
        end

        // Walk the clock to 23:59 through the set modes, checking every hour value.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "roll_set_h");
        for (int h = 1; h <= 23; h++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "roll_hinc");
            checkOutput($sformatf("roll_hour%0d", h), 0, h, SET_H, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "roll_set_m");
        for (int m = 1; m <= 60; m++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "roll_minc");
            if (m == 59 || m == 60) begin
                checkOutput($sformatf("set_m_wrap%0d", m), m % 60, 23, SET_M, 1'b1, 1'b0);
            end
        end
        for (int m = 1; m <= 59; m++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "roll_minc2");
        end
        checkOutput("preset_2359", 59, 23, SET_M, 1'b1, 1'b0);

        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "frozen");
        end
        checkOutput("frozen", 59, 23, SET_M, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "roll_to_run");
        checkOutput("roll_to_run", 59, 23, RUN, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rollover");
        checkOutput("rollover", 0, 0, RUN, 1'b0, 1'b0);

        for (int m = 1; m <= 60; m++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "hour_carry");
            if (m == 59) checkOutput("hour_carry59", 59, 0, RUN, 1'b0, 1'b0);
        end
        checkOutput("hour_carry", 0, 1, RUN, 1'b0, 1'b0);

        // Synchronous reset in SET_M, together with mode_btn, must not raise sec_clr.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mid_set_h");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "mid_set_m");
        for (int m = 0; m < 42; m++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "mid_minc");
        end
        checkOutput("mid_set_42", 42, 1, SET_M, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "mid_sync_reset");
        checkOutput("mid_sync_reset", 0, 0, RUN, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mid_sync_after");
        checkOutput("mid_sync_after", 0, 0, RUN, 1'b0, 1'b0);

        // Same again with the asynchronous reset pulsed between clock edges.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "async_set_h");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "async_hinc");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "async_set_m");
        for (int m = 0; m < 42; m++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "async_minc");
        end
        checkOutput("async_set_42", 42, 1, SET_M, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_mid_set", 0, 0, RUN, 1'b0, 1'b0);
        cmp("async_mid_set.day_carry", 32'(hmIf.day_carry), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "async_after");
        checkOutput("async_after", 1, 0, RUN, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
